// File: rtl/usb11_xact_builder_pkg.sv
// Shared constants and types for the USB 1.1 transaction builder: command-word
// bit layout, SYNC byte, CRC polynomials and the builder state encoding.
package usb11_xact_builder_pkg;

  // Command word layout: [7:0] byte, [8] channel, [9] read_lines, [10] set_rstena,
  // [11] wait_d, [12] autoack, [13] last_byte, [14] byte_out, [15] pkt.
  localparam int B_CHANNEL  = 8;
  localparam int B_WAIT_D   = 11;
  localparam int B_AUTOACK  = 12;
  localparam int B_LAST     = 13;
  localparam int B_BYTE_OUT = 14;
  localparam int B_PKT      = 15;

  localparam logic [7:0]  SYNC_BYTE  = 8'h80;
  localparam logic [4:0]  CRC5_POLY  = 5'h05;
  localparam logic [4:0]  CRC5_INIT  = 5'h1F;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  localparam logic [1:0] REQ_TOKEN = 2'd0;
  localparam logic [1:0] REQ_DATA  = 2'd1;
  localparam logic [1:0] REQ_RAW   = 2'd2;
  localparam logic [1:0] REQ_RSVD  = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE, ST_RAW, ST_T_SYNC, ST_T_PID, ST_T_B1, ST_T_B2,
    ST_D_SYNC, ST_D_PID, ST_D_BYTE, ST_D_CRCL, ST_D_CRCH
  } state_t;

  // Every generated packet byte is a byte_out word; read_lines/set_rstena stay 0.
  function automatic logic [15:0] mk_word(input logic [7:0] b, input logic ch,
                                          input logic pkt, input logic last,
                                          input logic ack);
    logic [15:0] w;
    w             = '0;
    w[7:0]        = b;
    w[B_CHANNEL]  = ch;
    w[B_BYTE_OUT] = 1'b1;
    w[B_PKT]      = pkt;
    w[B_LAST]     = last;
    w[B_AUTOACK]  = ack;
    w[B_WAIT_D]   = ack;
    return w;
  endfunction

endpackage

// File: rtl/usb11_xact_builder_if.sv
// Request, payload-write and command-word signals between the host logic
// (master) and the transaction builder (slave).
interface usb11_xact_builder_if;
  // Handshakes: a request transfers on a clock edge where req_valid & req_ready
  // are both high; fields must be stable in that cycle and are ignored after.
  // A command word transfers on every cycle cmd_wr is high (no backpressure on
  // that cycle); cmd_full low in a cycle allows the next word to be registered.
  logic        pl_wr;
  logic [2:0]  pl_addr;
  logic [7:0]  pl_data;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_type;
  logic        req_channel;
  logic [3:0]  req_pid;
  logic [6:0]  req_addr;
  logic [3:0]  req_endp;
  logic [3:0]  req_dpid;
  logic [3:0]  req_len;
  logic        req_autoack;
  logic [15:0] req_raw;
  logic        cmd_full;
  logic [15:0] cmd_data;
  logic        cmd_wr;
  logic        busy;

  modport master (
    output pl_wr, pl_addr, pl_data, req_valid, req_type, req_channel, req_pid,
           req_addr, req_endp, req_dpid, req_len, req_autoack, req_raw, cmd_full,
    input  req_ready, cmd_data, cmd_wr, busy
  );

  modport slave (
    input  pl_wr, pl_addr, pl_data, req_valid, req_type, req_channel, req_pid,
           req_addr, req_endp, req_dpid, req_len, req_autoack, req_raw, cmd_full,
    output req_ready, cmd_data, cmd_wr, busy
  );
endinterface

// File: rtl/usb11_xact_builder_crc.sv
// Token CRC5 (one 11-bit step) and data CRC16 (byte step) registers, both
// computed MSb-register / LSb-first-data as they appear on the USB wire.
module usb11_xact_builder_crc
  import usb11_xact_builder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        step,
  input  logic        sel,
  input  logic [10:0] din,
  output logic [4:0]  crc5,
  output logic [15:0] crc16
);

  function automatic logic [4:0] crc5_next(input logic [4:0] c, input logic [10:0] d);
    logic [4:0] r;
    r = c;
    for (int i = 0; i < 11; i++) begin
      if (d[i] ^ r[4]) r = {r[3:0], 1'b0} ^ CRC5_POLY;
      else             r = {r[3:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [15:0] crc16_next(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (d[i] ^ r[15]) r = {r[14:0], 1'b0} ^ CRC16_POLY;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // sel=0 folds addr/endp into CRC5, sel=1 folds one payload byte into CRC16.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc5  <= CRC5_INIT;
      crc16 <= CRC16_INIT;
    end else if (init) begin
      crc5  <= CRC5_INIT;
      crc16 <= CRC16_INIT;
    end else if (step) begin
      if (sel) crc16 <= crc16_next(crc16, din[7:0]);
      else     crc5  <= crc5_next(crc5, din);
    end
  end

endmodule

// File: rtl/usb11_xact_builder.sv
// Turns one host transaction request into the 16-bit command-word stream for
// usb11_ctrl: SYNC, PID, token fields with CRC5, optional DATAx with CRC16.
module usb11_xact_builder
  import usb11_xact_builder_pkg::*;
#(
  parameter int MAX_LEN = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  usb11_xact_builder_if.slave  bus,
  output state_t               dbg_state
);

  state_t      state;
  logic [7:0]  pl_mem [0:MAX_LEN-1];
  logic        data_q, ch_q, ack_q;
  logic [3:0]  pid_q, endp_q, dpid_q, len_q, cnt;
  logic [6:0]  addr_q;
  logic [15:0] raw_q;
  logic [15:0] cmd_data_q;
  logic        cmd_wr_q;

  logic        accept, emit, crc_step, crc_sel;
  logic [10:0] crc_din;
  logic [4:0]  crc5_q, crc5_tx;
  logic [15:0] crc16_q, crc16_tx, word;
  logic [7:0]  cur_byte;
  logic [3:0]  len_clamped;

  assign accept        = bus.req_valid && (state == ST_IDLE);
  assign emit          = (state != ST_IDLE) && !bus.cmd_full;
  assign bus.req_ready = (state == ST_IDLE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.cmd_data  = cmd_data_q;
  assign bus.cmd_wr    = cmd_wr_q;
  assign dbg_state     = state;
  assign cur_byte      = pl_mem[cnt[2:0]];
  assign len_clamped   = (bus.req_len > 4'(MAX_LEN)) ? 4'(MAX_LEN) : bus.req_len;

  // Payload buffer has no reset; the host fills it while the builder is idle.
  always_ff @(posedge clk) begin
    if (bus.pl_wr) pl_mem[bus.pl_addr] <= bus.pl_data;
  end

  usb11_xact_builder_crc u_crc (
    .clk   (clk),
    .reset (reset),
    .init  (accept),
    .step  (crc_step),
    .sel   (crc_sel),
    .din   (crc_din),
    .crc5  (crc5_q),
    .crc16 (crc16_q)
  );

  // CRCs go out inverted, MSb of the register first; bytes go out LSb first.
  always_comb begin
    crc5_tx  = '0;
    crc16_tx = '0;
    for (int i = 0; i < 5; i++)  crc5_tx[i]  = ~crc5_q[4-i];
    for (int i = 0; i < 16; i++) crc16_tx[i] = ~crc16_q[15-i];
  end

  always_comb begin
    word     = '0;
    crc_step = 1'b0;
    crc_sel  = 1'b0;
    crc_din  = {endp_q, addr_q};
    case (state)
      ST_RAW:    word = raw_q;
      ST_T_SYNC: begin
        word     = mk_word(SYNC_BYTE, ch_q, 1'b1, 1'b0, 1'b0);
        crc_step = emit;
      end
      ST_T_PID:  word = mk_word({~pid_q, pid_q}, ch_q, 1'b0, 1'b0, 1'b0);
      ST_T_B1:   word = mk_word({endp_q[0], addr_q}, ch_q, 1'b0, 1'b0, 1'b0);
      ST_T_B2:   word = mk_word({crc5_tx, endp_q[3:1]}, ch_q, 1'b0, 1'b1, ack_q);
      ST_D_SYNC: word = mk_word(SYNC_BYTE, ch_q, 1'b0, 1'b0, 1'b0);
      ST_D_PID:  word = mk_word({~dpid_q, dpid_q}, ch_q, 1'b0, 1'b0, 1'b0);
      ST_D_BYTE: begin
        word     = mk_word(cur_byte, ch_q, 1'b0, 1'b0, 1'b0);
        crc_step = emit;
        crc_sel  = 1'b1;
        crc_din  = {3'b000, cur_byte};
      end
      ST_D_CRCL: word = mk_word(crc16_tx[7:0], ch_q, 1'b0, 1'b0, 1'b0);
      ST_D_CRCH: word = mk_word(crc16_tx[15:8], ch_q, 1'b0, 1'b1, 1'b0);
      default:   word = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cmd_wr_q   <= 1'b0;
      cmd_data_q <= '0;
      cnt        <= '0;
      data_q     <= 1'b0;
      ch_q       <= 1'b0;
      ack_q      <= 1'b0;
      pid_q      <= '0;
      endp_q     <= '0;
      dpid_q     <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      raw_q      <= '0;
    end else begin
      cmd_wr_q <= 1'b0;
      if (emit) begin
        cmd_wr_q   <= 1'b1;
        cmd_data_q <= word;
      end
      case (state)
        ST_IDLE: if (accept) begin
          data_q <= (bus.req_type == REQ_DATA);
          ch_q   <= bus.req_channel;
          ack_q  <= bus.req_autoack;
          pid_q  <= bus.req_pid;
          endp_q <= bus.req_endp;
          dpid_q <= bus.req_dpid;
          len_q  <= len_clamped;
          addr_q <= bus.req_addr;
          raw_q  <= bus.req_raw;
          case (bus.req_type)
            REQ_TOKEN, REQ_DATA: state <= ST_T_SYNC;
            REQ_RAW:             state <= ST_RAW;
            REQ_RSVD:            state <= ST_IDLE;
            default:             state <= ST_IDLE;
          endcase
        end
        ST_RAW:    if (emit) state <= ST_IDLE;
        ST_T_SYNC: if (emit) state <= ST_T_PID;
        ST_T_PID:  if (emit) state <= ST_T_B1;
        ST_T_B1:   if (emit) state <= ST_T_B2;
        ST_T_B2:   if (emit) state <= data_q ? ST_D_SYNC : ST_IDLE;
        ST_D_SYNC: if (emit) state <= ST_D_PID;
        ST_D_PID:  if (emit) begin
          cnt   <= '0;
          state <= (len_q == 4'd0) ? ST_D_CRCL : ST_D_BYTE;
        end
        ST_D_BYTE: if (emit) begin
          cnt <= cnt + 4'd1;
          if (cnt + 4'd1 == len_q) state <= ST_D_CRCL;
        end
        ST_D_CRCL: if (emit) state <= ST_D_CRCH;
        ST_D_CRCH: if (emit) state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb11_xact_builder.sv
// Directed bench for usb11_xact_builder: expected command words are queued as
// each request is issued and a negedge monitor pops and compares them.
module tb_usb11_xact_builder;
  import usb11_xact_builder_pkg::*;

  logic   clk;
  logic   reset;
  state_t dbg_state;
  int     vectors = 0;
  int     miscompares = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  tb_pl [0:7];

  usb11_xact_builder_if bus_if ();

  usb11_xact_builder #(.MAX_LEN(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference helpers ----------------
  function automatic logic [15:0] w(input logic [7:0] b, input logic ch, input logic pkt,
                                    input logic last, input logic ack);
    return {pkt, 1'b1, last, ack, ack, 2'b00, ch, b};
  endfunction

  // Reflected (shift-right) forms of the USB CRCs; result bit 0 is sent first.
  function automatic logic [4:0] m_crc5(input logic [6:0] a, input logic [3:0] e);
    logic [10:0] d;
    logic [4:0]  c;
    d = {e, a};
    c = 5'h1F;
    for (int i = 0; i < 11; i++) c = (c[0] ^ d[i]) ? ((c >> 1) ^ 5'h14) : (c >> 1);
    return ~c;
  endfunction

  function automatic logic [15:0] m_crc16(input int n);
    logic [15:0] c;
    logic [7:0]  b;
    c = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      b = tb_pl[k];
      for (int i = 0; i < 8; i++) c = (c[0] ^ b[i]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_token(input logic ch, input logic [3:0] pid, input logic [6:0] addr,
                            input logic [3:0] endp, input logic ack);
    exp_q.push_back(w(8'h80, ch, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(w({~pid, pid}, ch, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(w({endp[0], addr}, ch, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(w({m_crc5(addr, endp), endp[3:1]}, ch, 1'b0, 1'b1, ack));
  endtask

  task automatic push_data(input logic ch, input logic [3:0] dpid, input int len);
    int n;
    logic [15:0] crc;
    n   = (len > 8) ? 8 : len;
    crc = m_crc16(n);
    exp_q.push_back(w(8'h80, ch, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(w({~dpid, dpid}, ch, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < n; k++) exp_q.push_back(w(tb_pl[k], ch, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(w(crc[7:0], ch, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(w(crc[15:8], ch, 1'b0, 1'b1, 1'b0));
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic [1:0] t, input logic ch, input logic [3:0] pid,
                          input logic [6:0] addr, input logic [3:0] endp,
                          input logic [3:0] dpid, input logic [3:0] len,
                          input logic ack, input logic [15:0] raw);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus_if.req_ready) ok = 1'b1;
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL req_ready_wait: got timeout, expected req_ready within 100 cycles");
      return;
    end
    bus_if.req_type    = t;
    bus_if.req_channel = ch;
    bus_if.req_pid     = pid;
    bus_if.req_addr    = addr;
    bus_if.req_endp    = endp;
    bus_if.req_dpid    = dpid;
    bus_if.req_len     = len;
    bus_if.req_autoack = ack;
    bus_if.req_raw     = raw;
    bus_if.req_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus_if.req_valid   = 1'b0;
    // Scramble fields so any late sampling shows up as wrong words.
    bus_if.req_channel = ~ch;
    bus_if.req_pid     = ~pid;
    bus_if.req_addr    = ~addr;
    bus_if.req_endp    = ~endp;
    bus_if.req_dpid    = ~dpid;
    bus_if.req_len     = ~len;
    bus_if.req_autoack = ~ack;
    bus_if.req_raw     = ~raw;
  endtask

  task automatic load_payload();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus_if.pl_wr   = 1'b1;
      bus_if.pl_addr = 3'(i);
      bus_if.pl_data = tb_pl[i];
    end
    @(negedge clk);
    bus_if.pl_wr = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !bus_if.busy) done = 1'b1;
    end
    check({name, "_drain"}, {31'd0, done}, 32'd1);
    check({name, "_ready"}, {31'd0, bus_if.req_ready}, 32'd1);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset && bus_if.cmd_wr) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL cmd_word: got %04h, expected no word", bus_if.cmd_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (bus_if.cmd_data !== e) begin
          miscompares++;
          $display("FAIL cmd_word: got %04h, expected %04h", bus_if.cmd_data, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset              = 1'b1;
    bus_if.pl_wr       = 1'b0;
    bus_if.pl_addr     = '0;
    bus_if.pl_data     = '0;
    bus_if.req_valid   = 1'b0;
    bus_if.req_type    = '0;
    bus_if.req_channel = 1'b0;
    bus_if.req_pid     = '0;
    bus_if.req_addr    = '0;
    bus_if.req_endp    = '0;
    bus_if.req_dpid    = '0;
    bus_if.req_len     = '0;
    bus_if.req_autoack = 1'b0;
    bus_if.req_raw     = '0;
    bus_if.cmd_full    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_wr",    {31'd0, bus_if.cmd_wr},    32'd0);
    check("rst_cmd_data",  {16'd0, bus_if.cmd_data},  32'd0);
    check("rst_req_ready", {31'd0, bus_if.req_ready}, 32'd1);
    check("rst_busy",      {31'd0, bus_if.busy},      32'd0);
    check("rst_state",     {28'd0, dbg_state},        {28'd0, ST_IDLE});
    reset = 1'b0;

    // SETUP addr0 ep0, token only; also checks first-word latency.
    exp_q.push_back(16'hC080); exp_q.push_back(16'h402D);
    exp_q.push_back(16'h4000); exp_q.push_back(16'h6010);
    send_req(REQ_TOKEN, 1'b0, 4'hD, 7'd0, 4'd0, 4'h3, 4'd0, 1'b0, 16'h0);
    check("lat_state",  {28'd0, dbg_state}, {28'd0, ST_T_SYNC});
    check("lat_wr_lo",  {31'd0, bus_if.cmd_wr}, 32'd0);
    @(posedge clk);
    #1;
    check("lat_wr_hi",  {31'd0, bus_if.cmd_wr}, 32'd1);
    check("lat_word",   {16'd0, bus_if.cmd_data}, 32'h0000C080);
    wait_drain("setup");

    // IN addr0 ep0, channel 1, autoack.
    exp_q.push_back(16'hC180); exp_q.push_back(16'h4169);
    exp_q.push_back(16'h4100); exp_q.push_back(16'h7910);
    send_req(REQ_TOKEN, 1'b1, 4'h9, 7'd0, 4'd0, 4'h3, 4'd0, 1'b1, 16'h0);
    wait_drain("in_ack");

    // OUT + DATA1, zero-length payload.
    exp_q.push_back(16'hC080); exp_q.push_back(16'h40E1);
    exp_q.push_back(16'h4000); exp_q.push_back(16'h6010);
    exp_q.push_back(16'h4080); exp_q.push_back(16'h404B);
    exp_q.push_back(16'h4000); exp_q.push_back(16'h6000);
    send_req(REQ_DATA, 1'b0, 4'h1, 7'd0, 4'd0, 4'hB, 4'd0, 1'b0, 16'h0);
    wait_drain("out_len0");

    // SETUP + DATA0 GET_DESCRIPTOR, 8 bytes.
    tb_pl[0] = 8'h80; tb_pl[1] = 8'h06; tb_pl[2] = 8'h00; tb_pl[3] = 8'h01;
    tb_pl[4] = 8'h00; tb_pl[5] = 8'h00; tb_pl[6] = 8'h40; tb_pl[7] = 8'h00;
    load_payload();
    exp_q.push_back(16'hC080); exp_q.push_back(16'h402D);
    exp_q.push_back(16'h4000); exp_q.push_back(16'h6010);
    push_data(1'b0, 4'h3, 8);
    send_req(REQ_DATA, 1'b0, 4'hD, 7'd0, 4'd0, 4'h3, 4'd8, 1'b0, 16'h0);
    wait_drain("setup_len8");

    // Same transaction with cmd_full toggling every cycle.
    exp_q.push_back(16'hC080); exp_q.push_back(16'h402D);
    exp_q.push_back(16'h4000); exp_q.push_back(16'h6010);
    push_data(1'b0, 4'h3, 8);
    send_req(REQ_DATA, 1'b0, 4'hD, 7'd0, 4'd0, 4'h3, 4'd8, 1'b0, 16'h0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      bus_if.cmd_full = ~bus_if.cmd_full;
      #1;
      if (exp_q.size() == 0 && !bus_if.busy) break;
    end
    bus_if.cmd_full = 1'b0;
    wait_drain("full_toggle");

    // OUT addr 0x15 ep 0xE, channel 1, DATA1 with len 12 clamped to 8.
    for (int i = 0; i < 8; i++) tb_pl[i] = 8'(i + 1);
    load_payload();
    push_token(1'b1, 4'h1, 7'h15, 4'hE, 1'b0);
    push_data(1'b1, 4'hB, 12);
    send_req(REQ_DATA, 1'b1, 4'h1, 7'h15, 4'hE, 4'hB, 4'd12, 1'b0, 16'h0);
    wait_drain("clamp");

    // Reserved type: accepted and dropped, no words.
    send_req(REQ_RSVD, 1'b0, 4'hD, 7'd3, 4'd1, 4'h3, 4'd2, 1'b0, 16'hFFFF);
    check("rsvd_state", {28'd0, dbg_state}, {28'd0, ST_IDLE});
    check("rsvd_busy",  {31'd0, bus_if.busy}, 32'd0);

    // Raw word, then reset in the middle of the following token.
    exp_q.push_back(16'h0402);
    exp_q.push_back(16'hC080);
    send_req(REQ_RAW, 1'b0, 4'h0, 7'd0, 4'd0, 4'h0, 4'd0, 1'b0, 16'h0402);
    send_req(REQ_TOKEN, 1'b0, 4'hD, 7'd0, 4'd0, 4'h3, 4'd0, 1'b0, 16'h0);
    @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_cmd_wr", {31'd0, bus_if.cmd_wr},    32'd0);
    check("abort_state",  {28'd0, dbg_state},        {28'd0, ST_IDLE});
    check("abort_ready",  {31'd0, bus_if.req_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort_busy",   {31'd0, bus_if.busy}, 32'd0);
    check("queue_empty",  exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
